// File: rtl/axi_pkg.sv
// AXI channel, request and response types shared by axi_rw_join and its error slave.
package axi_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [7:0]           len_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;
  typedef logic [1:0]           resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    len_t       len;
    logic [2:0] size;
    logic [1:0] burst;
  } ax_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_t   id;
    resp_t resp;
  } b_chan_t;

  typedef struct packed {
    id_t   id;
    data_t data;
    resp_t resp;
    logic  last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;

endpackage

// File: rtl/axi_rw_join_err_slv.sv
// DECERR responder for stray traffic on the unused channels of the split slave ports:
// a write FSM (read port's AW/W/B) and a read FSM (write port's AR/R), one burst each.
module axi_rw_join_err_slv
  import axi_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  id_t  aw_id,
  input  logic aw_valid,
  output logic aw_ready,
  input  logic w_valid,
  input  logic w_last,
  output logic w_ready,
  output logic b_valid,
  output id_t  b_id,
  input  logic b_ready,
  input  id_t  ar_id,
  input  len_t ar_len,
  input  logic ar_valid,
  output logic ar_ready,
  output logic r_valid,
  output id_t  r_id,
  output logic r_last,
  input  logic r_ready
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_RESP}         rd_state_e;

  wr_state_e wr_state;
  rd_state_e rd_state;
  len_t      beat_cnt;

  // NOTE: synchronous reset lives inside the clocked block, and every state update
  // uses <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_state <= W_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_id     <= '0;
    end else begin
      unique case (wr_state)
        W_IDLE: begin
          if (aw_valid && aw_ready) begin
            b_id     <= aw_id;
            aw_ready <= 1'b0;
            w_ready  <= 1'b1;
            wr_state <= W_DATA;
          end else begin
            aw_ready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_valid && w_ready && w_last) begin
            w_ready  <= 1'b0;
            b_valid  <= 1'b1;
            wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_ready) begin
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // r_last is kept registered as (beat_cnt == 0) so it is valid with the beat.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_state <= R_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_last   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          if (ar_valid && ar_ready) begin
            r_id     <= ar_id;
            beat_cnt <= ar_len;
            r_last   <= (ar_len == '0);
            ar_ready <= 1'b0;
            r_valid  <= 1'b1;
            rd_state <= R_RESP;
          end else begin
            ar_ready <= 1'b1;
          end
        end
        R_RESP: begin
          if (r_ready) begin
            if (r_last) begin
              r_valid  <= 1'b0;
              ar_ready <= 1'b1;
              rd_state <= R_IDLE;
            end else begin
              beat_cnt <= beat_cnt - len_t'(1);
              r_last   <= (beat_cnt == len_t'(1));
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_rw_join.sv
// Joins a read-only and a write-only AXI slave port into one master port with
// outstanding-burst throttling. Define AXI_RW_JOIN_ERR_EN to answer stray traffic with DECERR.
module axi_rw_join
  import axi_pkg::*;
#(
  parameter type         axi_req_t    = axi_pkg::axi_req_t,
  parameter type         axi_resp_t   = axi_pkg::axi_resp_t,
  parameter int unsigned MaxReadTxns  = 8,
  parameter int unsigned MaxWriteTxns = 8
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  slv_read_req_i,
  output axi_resp_t slv_read_resp_o,
  input  axi_req_t  slv_write_req_i,
  output axi_resp_t slv_write_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
);

  localparam int unsigned RdCntW = $clog2(MaxReadTxns + 1);
  localparam int unsigned WrCntW = $clog2(MaxWriteTxns + 1);

  logic [RdCntW-1:0] rd_cnt;
  logic [WrCntW-1:0] wr_cnt;
  logic rd_open, wr_open;
  logic ar_hs, r_done, aw_hs, b_done;

  // Gating uses the registered count only, so a completion at Max unblocks a cycle later.
  assign rd_open = (rd_cnt < RdCntW'(MaxReadTxns));
  assign wr_open = (wr_cnt < WrCntW'(MaxWriteTxns));
  assign ar_hs   = slv_read_req_i.ar_valid && rd_open && mst_resp_i.ar_ready;
  assign r_done  = mst_resp_i.r_valid && slv_read_req_i.r_ready && mst_resp_i.r.last;
  assign aw_hs   = slv_write_req_i.aw_valid && wr_open && mst_resp_i.aw_ready;
  assign b_done  = mst_resp_i.b_valid && slv_write_req_i.b_ready;

  logic unused_ok;
  assign unused_ok = ^{slv_read_req_i, slv_write_req_i};

`ifdef AXI_RW_JOIN_ERR_EN
  logic err_aw_ready, err_w_ready, err_b_valid, err_ar_ready, err_r_valid, err_r_last;
  id_t  err_b_id, err_r_id;

  axi_rw_join_err_slv u_err_slv (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .aw_id    (slv_read_req_i.aw.id),
    .aw_valid (slv_read_req_i.aw_valid),
    .aw_ready (err_aw_ready),
    .w_valid  (slv_read_req_i.w_valid),
    .w_last   (slv_read_req_i.w.last),
    .w_ready  (err_w_ready),
    .b_valid  (err_b_valid),
    .b_id     (err_b_id),
    .b_ready  (slv_read_req_i.b_ready),
    .ar_id    (slv_write_req_i.ar.id),
    .ar_len   (slv_write_req_i.ar.len),
    .ar_valid (slv_write_req_i.ar_valid),
    .ar_ready (err_ar_ready),
    .r_valid  (err_r_valid),
    .r_id     (err_r_id),
    .r_last   (err_r_last),
    .r_ready  (slv_write_req_i.r_ready)
  );
`endif

  always_comb begin
    // NOTE: whole-struct defaults first keep every field assigned on every path (no latches).
    mst_req_o        = '0;
    slv_read_resp_o  = '0;
    slv_write_resp_o = '0;

    mst_req_o.ar       = slv_read_req_i.ar;
    mst_req_o.ar_valid = slv_read_req_i.ar_valid && rd_open;
    mst_req_o.r_ready  = slv_read_req_i.r_ready;
    mst_req_o.aw       = slv_write_req_i.aw;
    mst_req_o.aw_valid = slv_write_req_i.aw_valid && wr_open;
    mst_req_o.w        = slv_write_req_i.w;
    mst_req_o.w_valid  = slv_write_req_i.w_valid;
    mst_req_o.b_ready  = slv_write_req_i.b_ready;

    slv_read_resp_o.ar_ready  = mst_resp_i.ar_ready && rd_open;
    slv_read_resp_o.r         = mst_resp_i.r;
    slv_read_resp_o.r_valid   = mst_resp_i.r_valid;
    slv_write_resp_o.aw_ready = mst_resp_i.aw_ready && wr_open;
    slv_write_resp_o.w_ready  = mst_resp_i.w_ready;
    slv_write_resp_o.b        = mst_resp_i.b;
    slv_write_resp_o.b_valid  = mst_resp_i.b_valid;

`ifdef AXI_RW_JOIN_ERR_EN
    slv_read_resp_o.aw_ready  = err_aw_ready;
    slv_read_resp_o.w_ready   = err_w_ready;
    slv_read_resp_o.b.id      = err_b_id;
    slv_read_resp_o.b.resp    = RESP_DECERR;
    slv_read_resp_o.b_valid   = err_b_valid;
    slv_write_resp_o.ar_ready = err_ar_ready;
    slv_write_resp_o.r.id     = err_r_id;
    slv_write_resp_o.r.resp   = RESP_DECERR;
    slv_write_resp_o.r.last   = err_r_last;
    slv_write_resp_o.r_valid  = err_r_valid;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_cnt <= '0;
    end else if (ar_hs && !r_done) begin
      rd_cnt <= rd_cnt + RdCntW'(1);
    end else if (r_done && !ar_hs && (rd_cnt != '0)) begin
      rd_cnt <= rd_cnt - RdCntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_cnt <= '0;
    end else if (aw_hs && !b_done) begin
      wr_cnt <= wr_cnt + WrCntW'(1);
    end else if (b_done && !aw_hs && (wr_cnt != '0)) begin
      wr_cnt <= wr_cnt - WrCntW'(1);
    end
  end

  rd_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(r_done && !ar_hs && (rd_cnt == '0)));
  wr_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(b_done && !aw_hs && (wr_cnt == '0)));

`ifndef AXI_RW_JOIN_ERR_EN
  no_stray_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(slv_read_req_i.aw_valid || slv_read_req_i.w_valid || slv_write_req_i.ar_valid));
`endif

endmodule

// File: tb/tb_axi_rw_join.sv
// Self-checking bench for axi_rw_join: table-driven passthrough/gating vectors plus
// directed multi-cycle sequences for counters, DECERR paths and reset.
module tb_axi_rw_join;
  import axi_pkg::*;

`ifdef AXI_RW_JOIN_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic      clk;
  logic      rst_n;
  axi_req_t  rd_req_a, wr_req_a, mst_req_a;
  axi_resp_t rd_resp_a, wr_resp_a, mst_resp_a;
  axi_req_t  rd_req_b, wr_req_b, mst_req_b;
  axi_resp_t rd_resp_b, wr_resp_b, mst_resp_b;

  int checks   = 0;
  int failures = 0;

  axi_rw_join #(.MaxReadTxns(2), .MaxWriteTxns(2)) dut_a (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .slv_read_req_i   (rd_req_a),
    .slv_read_resp_o  (rd_resp_a),
    .slv_write_req_i  (wr_req_a),
    .slv_write_resp_o (wr_resp_a),
    .mst_req_o        (mst_req_a),
    .mst_resp_i       (mst_resp_a)
  );

  axi_rw_join #(.MaxReadTxns(4), .MaxWriteTxns(4)) dut_b (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .slv_read_req_i   (rd_req_b),
    .slv_read_resp_o  (rd_resp_b),
    .slv_write_req_i  (wr_req_b),
    .slv_write_resp_o (wr_resp_b),
    .mst_req_o        (mst_req_b),
    .mst_resp_i       (mst_resp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; checks run 1 ns later, far from the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        rd_arv, m_arr, wr_awv, m_awr, wr_wv, m_wr;
    logic [3:0]  id;
    logic [31:0] data;
    logic        e_m_arv, e_rd_arr, e_m_awv, e_wr_awr, e_m_wv, e_wr_wr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1,1,0,1,1,0, 4'h1, 32'h1111_1111, 1,1,0,1,1,0};
    vecs[1] = '{0,1,1,0,0,1, 4'h2, 32'hDEAD_BEEF, 0,1,1,0,0,1};
    vecs[2] = '{1,0,1,1,1,1, 4'h7, 32'h0000_0000, 1,0,1,1,1,1};
    vecs[3] = '{0,0,0,0,0,0, 4'hF, 32'hFFFF_FFFF, 0,0,0,0,0,0};
    vecs[4] = '{1,1,1,1,0,0, 4'hA, 32'h1234_5678, 1,1,1,1,0,0};

    rd_req_a = '0; wr_req_a = '0; mst_resp_a = '0;
    rd_req_b = '0; wr_req_b = '0; mst_resp_b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    step();
    rst_n = 1'b1;
    #1;
    check("reset_rd_cnt", 32'(dut_a.rd_cnt), 0);
    check("reset_wr_cnt", 32'(dut_a.wr_cnt), 0);
    check("reset_mst_ar_valid", 32'(mst_req_a.ar_valid), 0);
    check("reset_err_ar_ready", 32'(wr_resp_a.ar_ready), 0);
    check("reset_err_aw_ready", 32'(rd_resp_a.aw_ready), 0);
    check("reset_err_r_valid", 32'(wr_resp_a.r_valid), 0);
    check("reset_err_b_valid", 32'(rd_resp_a.b_valid), 0);
    step(); #1;
    check("unused_ar_ready", 32'(wr_resp_a.ar_ready), 32'(ErrEn));
    check("unused_aw_ready", 32'(rd_resp_a.aw_ready), 32'(ErrEn));
    check("unused_w_ready", 32'(rd_resp_a.w_ready), 0);

    // Combinational vectors; valids drop again before the rising edge so no handshake counts.
    for (int i = 0; i < 5; i++) begin
      step();
      rd_req_a.ar_valid   = vecs[i].rd_arv;
      rd_req_a.ar.id      = vecs[i].id;
      rd_req_a.ar.addr    = vecs[i].data;
      mst_resp_a.ar_ready = vecs[i].m_arr;
      wr_req_a.aw_valid   = vecs[i].wr_awv;
      wr_req_a.aw.id      = vecs[i].id;
      mst_resp_a.aw_ready = vecs[i].m_awr;
      wr_req_a.w_valid    = vecs[i].wr_wv;
      wr_req_a.w.data     = vecs[i].data;
      mst_resp_a.w_ready  = vecs[i].m_wr;
      mst_resp_a.r.data   = vecs[i].data;
      mst_resp_a.b.id     = vecs[i].id;
      #1;
      check("vec_mst_ar_valid", 32'(mst_req_a.ar_valid), 32'(vecs[i].e_m_arv));
      check("vec_rd_ar_ready", 32'(rd_resp_a.ar_ready), 32'(vecs[i].e_rd_arr));
      check("vec_mst_aw_valid", 32'(mst_req_a.aw_valid), 32'(vecs[i].e_m_awv));
      check("vec_wr_aw_ready", 32'(wr_resp_a.aw_ready), 32'(vecs[i].e_wr_awr));
      check("vec_mst_w_valid", 32'(mst_req_a.w_valid), 32'(vecs[i].e_m_wv));
      check("vec_wr_w_ready", 32'(wr_resp_a.w_ready), 32'(vecs[i].e_wr_wr));
      check("vec_ar_id", 32'(mst_req_a.ar.id), 32'(vecs[i].id));
      check("vec_ar_addr", 32'(mst_req_a.ar.addr), vecs[i].data);
      check("vec_w_data", 32'(mst_req_a.w.data), vecs[i].data);
      check("vec_r_data", 32'(rd_resp_a.r.data), vecs[i].data);
      check("vec_b_id", 32'(wr_resp_a.b.id), 32'(vecs[i].id));
      rd_req_a = '0; wr_req_a = '0; mst_resp_a = '0;
    end

    // Read counter limit (MaxReadTxns = 2).
    step();
    rd_req_a.ar_valid = 1'b1; rd_req_a.ar.id = 4'd1; mst_resp_a.ar_ready = 1'b1;
    #1 check("lim_ar1_ready", 32'(rd_resp_a.ar_ready), 1);
    step();
    rd_req_a.ar.id = 4'd2;
    #1 check("lim_ar2_ready", 32'(rd_resp_a.ar_ready), 1);
    step();
    rd_req_a.ar.id = 4'd3;
    #1 check("lim_ar3_ready", 32'(rd_resp_a.ar_ready), 0);
    check("lim_ar3_mst_valid", 32'(mst_req_a.ar_valid), 0);
    step();
    mst_resp_a.r_valid = 1'b1; mst_resp_a.r.last = 1'b1; rd_req_a.r_ready = 1'b1;
    #1 check("lim_same_cycle_blocked", 32'(rd_resp_a.ar_ready), 0);
    step();
    mst_resp_a.r_valid = 1'b0;
    #1 check("lim_ar3_unblocked", 32'(rd_resp_a.ar_ready), 1);
    check("lim_ar3_mst_valid2", 32'(mst_req_a.ar_valid), 1);
    step();
    rd_req_a.ar_valid = 1'b0; mst_resp_a.r_valid = 1'b1; mst_resp_a.r.last = 1'b0;
    #1 check("lim_rd_cnt_full", 32'(dut_a.rd_cnt), 2);
    step();
    mst_resp_a.r.last = 1'b1;
    #1 check("lim_nonlast_no_dec", 32'(dut_a.rd_cnt), 2);
    repeat (2) step();
    rd_req_a = '0; mst_resp_a = '0;
    #1 check("lim_rd_cnt_drained", 32'(dut_a.rd_cnt), 0);

    // Write counter with same-cycle AW and B.
    step();
    wr_req_a.aw_valid = 1'b1; mst_resp_a.aw_ready = 1'b1;
    step();
    mst_resp_a.b_valid = 1'b1; wr_req_a.b_ready = 1'b1;
    #1 check("wr_same_aw_ready", 32'(wr_resp_a.aw_ready), 1);
    check("wr_cnt_one", 32'(dut_a.wr_cnt), 1);
    step();
    mst_resp_a.b_valid = 1'b0;
    #1 check("wr_same_cycle_hold", 32'(dut_a.wr_cnt), 1);
    step();
    #1 check("wr_cnt_full", 32'(dut_a.wr_cnt), 2);
    check("wr_full_aw_ready", 32'(wr_resp_a.aw_ready), 0);
    check("wr_full_mst_aw_valid", 32'(mst_req_a.aw_valid), 0);
    mst_resp_a.b_valid = 1'b1;
    #1 check("wr_full_b_same_cycle", 32'(wr_resp_a.aw_ready), 0);
    step();
    mst_resp_a.b_valid = 1'b0; wr_req_a.aw_valid = 1'b0;
    #1 check("wr_cnt_after_b", 32'(dut_a.wr_cnt), 1);
    step();
    mst_resp_a.b_valid = 1'b1;
    step();
    wr_req_a = '0; mst_resp_a = '0;
    #1 check("wr_cnt_drained", 32'(dut_a.wr_cnt), 0);

    // Mixed 4-beat write and 4-beat read.
    step();
    rd_req_a.ar_valid = 1'b1; rd_req_a.ar.id = 4'd3; rd_req_a.ar.len = 8'd3;
    wr_req_a.aw_valid = 1'b1; wr_req_a.aw.id = 4'd6; wr_req_a.aw.len = 8'd3;
    mst_resp_a.ar_ready = 1'b1; mst_resp_a.aw_ready = 1'b1;
    #1 check("mix_ar_id", 32'(mst_req_a.ar.id), 3);
    check("mix_aw_id", 32'(mst_req_a.aw.id), 6);
    check("mix_aw_len", 32'(mst_req_a.aw.len), 3);
    for (int i = 0; i < 4; i++) begin
      step();
      rd_req_a.ar_valid = 1'b0; wr_req_a.aw_valid = 1'b0;
      wr_req_a.w_valid = 1'b1; wr_req_a.w.data = 32'hA0 + 32'(i); wr_req_a.w.last = (i == 3);
      mst_resp_a.w_ready = 1'b1;
      mst_resp_a.r_valid = 1'b1; mst_resp_a.r.id = 4'd3;
      mst_resp_a.r.data = 32'hB0 + 32'(i); mst_resp_a.r.last = (i == 3);
      rd_req_a.r_ready = 1'b1;
      #1 check("mix_w_data", 32'(mst_req_a.w.data), 32'hA0 + 32'(i));
      check("mix_w_last", 32'(mst_req_a.w.last), 32'(i == 3));
      check("mix_r_data", 32'(rd_resp_a.r.data), 32'hB0 + 32'(i));
      check("mix_r_id", 32'(rd_resp_a.r.id), 3);
    end
    step();
    wr_req_a.w_valid = 1'b0; mst_resp_a.r_valid = 1'b0; rd_req_a.r_ready = 1'b0;
    mst_resp_a.b_valid = 1'b1; mst_resp_a.b.id = 4'd6; mst_resp_a.b.resp = RESP_OKAY;
    wr_req_a.b_ready = 1'b1;
    #1 check("mix_rd_cnt_done", 32'(dut_a.rd_cnt), 0);
    check("mix_b_id", 32'(wr_resp_a.b.id), 6);
    check("mix_b_valid", 32'(wr_resp_a.b_valid), 1);
    step();
    rd_req_a = '0; wr_req_a = '0; mst_resp_a = '0;
    #1 check("mix_wr_cnt_done", 32'(dut_a.wr_cnt), 0);

`ifdef AXI_RW_JOIN_ERR_EN
    // Stray read on the write port.
    step();
    wr_req_a.ar_valid = 1'b1; wr_req_a.ar.id = 4'd5; wr_req_a.ar.len = 8'd3;
    #1 check("err_ar_ready", 32'(wr_resp_a.ar_ready), 1);
    check("err_ar_not_forwarded", 32'(mst_req_a.ar_valid), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      wr_req_a.ar_valid = 1'b0; wr_req_a.r_ready = 1'b1;
      #1 check("err_r_valid", 32'(wr_resp_a.r_valid), 1);
      check("err_r_id", 32'(wr_resp_a.r.id), 5);
      check("err_r_data", 32'(wr_resp_a.r.data), 0);
      check("err_r_resp", 32'(wr_resp_a.r.resp), 32'(RESP_DECERR));
      check("err_r_last", 32'(wr_resp_a.r.last), 32'(i == 3));
    end
    step();
    wr_req_a = '0;
    #1 check("err_r_done", 32'(wr_resp_a.r_valid), 0);

    // Stray write on the read port, W offered before AW.
    rd_req_a.w_valid = 1'b1;
    #1 check("err_w_waits_idle", 32'(rd_resp_a.w_ready), 0);
    rd_req_a.aw_valid = 1'b1; rd_req_a.aw.id = 4'd2;
    #1 check("err_aw_ready", 32'(rd_resp_a.aw_ready), 1);
    step();
    rd_req_a.aw_valid = 1'b0;
    #1 check("err_w_ready", 32'(rd_resp_a.w_ready), 1);
    step();
    rd_req_a.w.last = 1'b1;
    #1 check("err_b_not_yet", 32'(rd_resp_a.b_valid), 0);
    step();
    rd_req_a.w_valid = 1'b0; rd_req_a.w.last = 1'b0;
    #1 check("err_b_valid", 32'(rd_resp_a.b_valid), 1);
    check("err_b_id", 32'(rd_resp_a.b.id), 2);
    check("err_b_resp", 32'(rd_resp_a.b.resp), 32'(RESP_DECERR));
    check("err_aw_not_forwarded", 32'(mst_req_a.aw_valid), 0);
    step();
    #1 check("err_b_hold", 32'(rd_resp_a.b_valid), 1);
    rd_req_a.b_ready = 1'b1;
    step();
    rd_req_a = '0;
    #1 check("err_b_done", 32'(rd_resp_a.b_valid), 0);
`else
    check("tie_b_valid", 32'(rd_resp_a.b_valid), 0);
    check("tie_r_valid", 32'(wr_resp_a.r_valid), 0);
    check("tie_r_data", 32'(wr_resp_a.r.data), 0);
`endif

    // Reset mid-burst on the Max=4 instance.
    step();
    rd_req_b.ar_valid = 1'b1; mst_resp_b.ar_ready = 1'b1;
    repeat (3) step();
    rd_req_b.ar_valid = 1'b0;
    #1 check("rst_rd_cnt_three", 32'(dut_b.rd_cnt), 3);
`ifdef AXI_RW_JOIN_ERR_EN
    wr_req_b.ar_valid = 1'b1; wr_req_b.ar.id = 4'd9; wr_req_b.ar.len = 8'd3;
    step();
    wr_req_b.ar_valid = 1'b0;
    #1 check("rst_err_in_resp", 32'(wr_resp_b.r_valid), 1);
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1 check("rst_rd_cnt_zero", 32'(dut_b.rd_cnt), 0);
    check("rst_err_r_valid", 32'(wr_resp_b.r_valid), 0);
    check("rst_err_ar_ready", 32'(wr_resp_b.ar_ready), 0);
    step();
    #1 check("rst_err_idle", 32'(wr_resp_b.ar_ready), 32'(ErrEn));
    check("rst_ar_open", 32'(rd_resp_b.ar_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
